// File: rtl/ticket_feeder.sv
// Entry-side ticket buffer for the lottery checker: collects DIGITS BCD digits,
// then replays them one strobe at a time and closes the ticket with fim_jogo.
module ticket_feeder #(
  parameter int DIGITS = 5,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       start,
  output logic [3:0] num,
  output logic       insere,
  output logic       fim_jogo,
  output logic [2:0] count,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {S_COLLECT, S_SEND, S_WAIT, S_END} state_t;

  localparam logic [2:0] FULL   = 3'(DIGITS);
  localparam logic [2:0] LAST   = 3'(DIGITS - 1);
  localparam logic [3:0] GAP_LD = 4'((GAP > 0) ? (GAP - 1) : 0);

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] num_q, num_d;
  logic       insere_q, insere_d;
  logic       fim_q, fim_d;
  logic       err_q, err_d;
  logic [3:0] buf_q [DIGITS];
  logic [3:0] buf_d [DIGITS];

  logic [2:0] idx_nxt;
  logic [3:0] digit_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_COLLECT;
      count_q  <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      num_q    <= '0;
      insere_q <= 1'b0;
      fim_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      num_q    <= num_d;
      insere_q <= insere_d;
      fim_q    <= fim_d;
      err_q    <= err_d;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    idx_nxt   = idx_q + 3'd1;
    digit_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == 3'(i)) digit_nxt = buf_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    num_d    = num_q;
    insere_d = 1'b0;
    fim_d    = 1'b0;
    err_d    = 1'b0;
    for (int i = 0; i < DIGITS; i++) buf_d[i] = buf_q[i];

    case (state_q)
      S_COLLECT: begin
        if (clear) begin
          count_d = '0;
        end else if (start) begin
          if (count_q == FULL) begin
            idx_d    = '0;
            num_d    = buf_q[0];
            insere_d = 1'b1;
            state_d  = S_SEND;
          end else begin
            err_d = 1'b1;
          end
        end else if (digit_valid) begin
          if (digit_in > 4'd9 || count_q == FULL) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (count_q == 3'(i)) buf_d[i] = digit_in;
            end
            count_d = count_q + 3'd1;
          end
        end
      end

      S_SEND, S_WAIT: begin
        // Abort still routes through S_END so the checker sees exactly one fim_jogo.
        if (clear) begin
          state_d = S_END;
          fim_d   = 1'b1;
          count_d = '0;
        end else if (state_q == S_SEND && GAP > 0) begin
          state_d = S_WAIT;
          gap_d   = GAP_LD;
        end else if (state_q == S_WAIT && gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (idx_q == LAST) begin
          state_d = S_END;
          fim_d   = 1'b1;
          count_d = '0;
        end else begin
          idx_d    = idx_nxt;
          num_d    = digit_nxt;
          insere_d = 1'b1;
          state_d  = S_SEND;
        end
      end

      S_END: begin
        state_d = S_COLLECT;
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  assign num      = num_q;
  assign insere   = insere_q;
  assign fim_jogo = fim_q;
  assign count    = count_q;
  assign busy     = (state_q != S_COLLECT);
  assign err      = err_q;

endmodule

// File: tb/tb_ticket_feeder.sv
// Directed bench for ticket_feeder: a GAP=1 and a GAP=0 instance share stimulus.
module tb_ticket_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, start, dv;
  logic [3:0] digit_in;

  logic [3:0] num1, num0;
  logic       ins1, ins0, fim1, fim0, busy1, busy0, err1, err0;
  logic [2:0] cnt1, cnt0;

  int checks   = 0;
  int failures = 0;

  ticket_feeder #(.DIGITS(5), .GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(dv),
    .clear(clear), .start(start), .num(num1), .insere(ins1),
    .fim_jogo(fim1), .count(cnt1), .busy(busy1), .err(err1)
  );

  ticket_feeder #(.DIGITS(5), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(dv),
    .clear(clear), .start(start), .num(num0), .insere(ins0),
    .fim_jogo(fim0), .count(cnt0), .busy(busy0), .err(err0)
  );

  typedef struct {
    logic       clr, st, dv;
    logic [3:0] d;
    logic [2:0] cnt;
    logic       err, busy, ins, fim;
    logic [3:0] num;
    logic       g0_ins, g0_fim;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic c, input logic s, input logic v, input logic [3:0] d);
    clear    = c;
    start    = s;
    dv       = v;
    digit_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic key5(input logic [3:0] a, b, c, d, e);
    cycle(0, 0, 1, a);
    cycle(0, 0, 1, b);
    cycle(0, 0, 1, c);
    cycle(0, 0, 1, d);
    cycle(0, 0, 1, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nins, nfim;
    //            clr st dv d     cnt err busy ins fim num g0i g0f
    tbl[0]  = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[1]  = '{0, 0, 1, 4'h4, 1, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[2]  = '{0, 0, 1, 4'h7, 2, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[3]  = '{0, 0, 1, 4'hA, 2, 1, 0, 0, 0, 4'h0, 0, 0};
    tbl[4]  = '{0, 0, 1, 4'h0, 3, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[5]  = '{0, 1, 0, 4'h0, 3, 1, 0, 0, 0, 4'h0, 0, 0};
    tbl[6]  = '{0, 0, 1, 4'h1, 4, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[7]  = '{0, 0, 1, 4'h9, 5, 0, 0, 0, 0, 4'h0, 0, 0};
    tbl[8]  = '{0, 0, 1, 4'h5, 5, 1, 0, 0, 0, 4'h0, 0, 0};
    tbl[9]  = '{0, 1, 0, 4'h0, 5, 0, 1, 1, 0, 4'h4, 1, 0};
    tbl[10] = '{0, 0, 0, 4'h0, 5, 0, 1, 0, 0, 4'h4, 1, 0};
    tbl[11] = '{0, 0, 0, 4'h0, 5, 0, 1, 1, 0, 4'h7, 1, 0};
    tbl[12] = '{0, 0, 1, 4'h3, 5, 0, 1, 0, 0, 4'h7, 1, 0};
    tbl[13] = '{0, 0, 0, 4'h0, 5, 0, 1, 1, 0, 4'h0, 1, 0};
    tbl[14] = '{0, 1, 0, 4'h0, 5, 0, 1, 0, 0, 4'h0, 0, 1};
    tbl[15] = '{0, 0, 0, 4'h0, 5, 0, 1, 1, 0, 4'h1, 0, 0};
    tbl[16] = '{0, 0, 0, 4'h0, 5, 0, 1, 0, 0, 4'h1, 0, 0};
    tbl[17] = '{0, 0, 0, 4'h0, 5, 0, 1, 1, 0, 4'h9, 0, 0};
    tbl[18] = '{0, 0, 0, 4'h0, 5, 0, 1, 0, 0, 4'h9, 0, 0};
    tbl[19] = '{0, 0, 0, 4'h0, 0, 0, 1, 0, 1, 4'h9, 0, 0};
    tbl[20] = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h9, 0, 0};

    reset = 1'b0; clear = 0; start = 0; dv = 0; digit_in = '0;
    #2;
    chk("rst_num", num1, 0);
    chk("rst_insere", ins1, 0);
    chk("rst_fim", fim1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_err", err1, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].clr, tbl[i].st, tbl[i].dv, tbl[i].d);
      chk($sformatf("v%0d_count", i), cnt1, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err1, tbl[i].err);
      chk($sformatf("v%0d_busy", i), busy1, tbl[i].busy);
      chk($sformatf("v%0d_insere", i), ins1, tbl[i].ins);
      chk($sformatf("v%0d_fim", i), fim1, tbl[i].fim);
      chk($sformatf("v%0d_num", i), num1, tbl[i].num);
      chk($sformatf("v%0d_g0_insere", i), ins0, tbl[i].g0_ins);
      chk($sformatf("v%0d_g0_fim", i), fim0, tbl[i].g0_fim);
    end

    // Priority: clear beats start and digit_valid with a full buffer.
    key5(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
    chk("prio_full", cnt1, 5);
    cycle(1, 1, 1, 4'h3);
    chk("prio_count", cnt1, 0);
    chk("prio_err", err1, 0);
    chk("prio_insere", ins1, 0);
    chk("prio_busy", busy1, 0);
    chk("prio_g0_count", cnt0, 0);
    cycle(0, 0, 0, 4'h0);
    chk("prio_busy_after", busy1, 0);
    chk("prio_insere_after", ins1, 0);

    // Clear of a partial ticket.
    cycle(0, 0, 1, 4'h8);
    cycle(0, 0, 1, 4'h8);
    cycle(0, 0, 1, 4'h8);
    chk("part_count", cnt1, 3);
    cycle(1, 0, 0, 4'h0);
    chk("part_clear_count", cnt1, 0);
    chk("part_clear_err", err1, 0);

    // GAP=0 playback aborted after the second digit.
    key5(4'h4, 4'h7, 4'h0, 4'h1, 4'h9);
    cycle(0, 1, 0, 4'h0);
    chk("g0_d0_insere", ins0, 1);
    chk("g0_d0_num", num0, 4);
    cycle(0, 0, 0, 4'h0);
    chk("g0_d1_insere", ins0, 1);
    chk("g0_d1_num", num0, 7);
    cycle(1, 0, 0, 4'h0);
    chk("g0_abort_insere", ins0, 0);
    chk("g0_abort_fim", fim0, 1);
    chk("g0_abort_busy", busy0, 1);
    chk("g0_abort_count", cnt0, 0);
    chk("g1_abort_fim", fim1, 1);
    nins = 0; nfim = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 4'h0);
      nins += int'(ins0);
      nfim += int'(fim0);
    end
    chk("g0_abort_extra_insere", nins, 0);
    chk("g0_abort_extra_fim", nfim, 0);
    chk("g0_abort_idle", busy0, 0);

    // Reset asserted while the GAP=1 instance sits in its gap.
    key5(4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    cycle(0, 1, 0, 4'h0);
    chk("rw_insere", ins1, 1);
    cycle(0, 0, 0, 4'h0);
    chk("rw_in_gap", ins1, 0);
    chk("rw_busy", busy1, 1);
    #2 reset = 1'b0;
    #1;
    chk("rw_num", num1, 0);
    chk("rw_busy_now", busy1, 0);
    chk("rw_count", cnt1, 0);
    chk("rw_insere_now", ins1, 0);
    chk("rw_fim_now", fim1, 0);
    chk("rw_g0_busy", busy0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    nfim = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 4'h0);
      nfim += int'(fim1);
    end
    chk("rw_no_fim", nfim, 0);
    cycle(0, 1, 0, 4'h0);
    chk("rw_start_err", err1, 1);
    chk("rw_start_busy", busy1, 0);
    chk("rw_start_insere", ins1, 0);
    cycle(0, 0, 0, 4'h0);
    chk("rw_err_pulse", err1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ticket_feeder.md
Name: ticket_feeder

Overview:
- Upstream stage of the lottery checker.
- Collects one ticket of DIGITS BCD digits from the entry keypad and buffers it.
- On start, replays the digits one per strobe on num/insere, then issues a one-cycle fim_jogo so the checker returns to its idle state.
- Provides entry-side status (count, busy, err) for the panel.

Parameters:
DIGITS, 5, ticket length in digits; legal range 1..7
GAP, 1, idle cycles between consecutive insere strobes and before fim_jogo; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
digit_in  input  4  BCD digit from keypad
digit_valid  input  1  one-cycle strobe; digit_in valid
clear  input  1  discard buffered digits, or abort playback while busy
start  input  1  request playback of the buffered ticket
num  output  4  digit presented to checker
insere  output  1  one-cycle strobe; num valid
fim_jogo  output  1  one-cycle end-of-ticket pulse to checker
count  output  3  digits currently buffered
busy  output  1  high while not in COLLECT
err  output  1  one-cycle pulse flagging a rejected request

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT; count, buffer, idx and gap counter = 0.
  - num=0, insere=0, fim_jogo=0, busy=0, err=0.
- All outputs are registered. insere, fim_jogo and err are exactly one cycle wide.
- COLLECT state. Priority in one cycle: clear > start > digit_valid.
  - clear: count<=0. No err.
  - start with count==DIGITS: idx<=0; num<=buf[0]; insere<=1 at the same edge; enter SEND.
  - start with count<DIGITS: err<=1; stay in COLLECT; buffer unchanged.
  - digit_valid with digit_in<=9 and count<DIGITS: buf[count]<=digit_in; count<=count+1.
  - digit_valid with digit_in>9: err<=1; digit dropped.
  - digit_valid with count==DIGITS: err<=1; digit dropped, no overwrite.
  - A lower-priority request in the same cycle as a higher-priority one is ignored with no err.
- SEND state (just issued buf[idx]):
  - If GAP>0: go to WAIT for GAP cycles.
  - If GAP==0: emit the next digit on the next edge.
  - After digit DIGITS-1 is issued, the next step is the END path (after GAP idle cycles when GAP>0), not another digit.
- WAIT state:
  - insere=0; num holds the last digit.
  - When the gap counter expires, issue the next digit, or go to END after the last one.
- END state:
  - fim_jogo<=1 for one cycle; count<=0; return to COLLECT. Buffer contents are not cleared.
- Timing: with start sampled at edge E0, digit k is on insere after edge E0+k*(GAP+1). fim_jogo follows the last insere by GAP+1 edges.
- While busy:
  - digit_valid and start are ignored; no err.
  - clear aborts: insere is forced to 0 at the next edge and END is entered, so fim_jogo still fires exactly once.
- Asserting reset mid-playback kills it immediately. No fim_jogo is issued.
- busy=1 in SEND, WAIT and END; busy=0 only in COLLECT.

Test Plan:
- Key in 4,7,0,1,9, then start (GAP=1) -> insere after E0,E2,E4,E6,E8 with num=4,7,0,1,9; fim_jogo after E10; count 5->0; busy high E0..E10.
- Key in 3 digits, then start -> err pulse, busy stays 0, no insere; then clear -> count=0.
- digit_in=4'hA with digit_valid -> err pulse, count unchanged. Sixth digit with count=5 -> err, buf[4] unchanged.
- Same cycle clear+start+digit_valid with count=5 -> count=0, no playback, no err.
- GAP=0 ticket 4,7,0,1,9 -> insere high 5 consecutive cycles, fim_jogo the following cycle. clear after the 2nd digit -> no further insere, exactly one fim_jogo.
- reset pulled low during WAIT -> all outputs 0 immediately. After release, start with count=0 -> err.
